jpeg_sos_gen: RTL and testbench

JPEG_SOS_GEN -- requirements
Module: jpeg_sos_gen

---
 rtl/jpeg_sos_gen.sv | 141 ++++++++++++++
 tb/tb_jpeg_sos_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_sos_gen.sv
// JPEG Start-Of-Scan header generator: emits FF DA, Ls, Ns, component selectors and Ss/Se/AhAl.
// Optional macro JPEG_SOS_GEN_LAST_EN drives out_last on the AhAl byte; otherwise out_last is tied to 0.
module jpeg_sos_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  ncomp,
  input  logic [3:0]  dc_ht_0,
  input  logic [3:0]  dc_ht_1,
  input  logic [3:0]  dc_ht_2,
  input  logic [3:0]  ac_ht_0,
  input  logic [3:0]  ac_ht_1,
  input  logic [3:0]  ac_ht_2,
  input  logic [23:0] spec,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte transfers on a rising edge where out_valid && out_ready; once out_valid
  // rises, out_byte and out_valid hold until that transfer happens.
  typedef enum logic [2:0] {IDLE, MARK, LEN, NCOMP, COMP, SPEC, DONE} state_t;

  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic [1:0]  ns_q;
  logic [2:0][3:0] dc_q, ac_q;
  logic [23:0] spec_q;
  logic        accept, ns_bad, fire, comp_end;
  logic [1:0]  idx;
  logic [3:0]  dc_sel, ac_sel;

  assign accept   = start && (state == IDLE);
  assign ns_bad   = (ncomp == 8'd0) || (ncomp > 8'd3);
  assign fire     = out_valid && out_ready;
  assign idx      = cnt[2:1];
  assign comp_end = (cnt == (({1'b0, ns_q}) << 1) - 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 3'd0;
      ns_q   <= 2'd0;
      dc_q   <= '0;
      ac_q   <= '0;
      spec_q <= 24'd0;
      err    <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (accept) begin
        ns_q   <= ncomp[1:0];
        dc_q   <= {dc_ht_2, dc_ht_1, dc_ht_0};
        ac_q   <= {ac_ht_2, ac_ht_1, ac_ht_0};
        spec_q <= spec;
        err    <= ns_bad;
      end
    end
  end

  always_comb begin
    dc_sel = dc_q[2];
    ac_sel = ac_q[2];
    case (idx)
      2'd0: begin dc_sel = dc_q[0]; ac_sel = ac_q[0]; end
      2'd1: begin dc_sel = dc_q[1]; ac_sel = ac_q[1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    if (fire) cnt_d = cnt + 3'd1;
    case (state)
      IDLE: begin
        // An illegal Ns skips the byte stream entirely and still produces a done pulse.
        if (accept) state_d = ns_bad ? DONE : MARK;
      end
      MARK: begin
        out_valid = 1'b1;
        out_byte  = (cnt == 3'd0) ? 8'hFF : 8'hDA;
        if (fire && cnt == 3'd1) begin state_d = LEN; cnt_d = 3'd0; end
      end
      LEN: begin
        out_valid = 1'b1;
        out_byte  = (cnt == 3'd0) ? 8'h00 : 8'd6 + {5'd0, ns_q, 1'b0};
        if (fire && cnt == 3'd1) begin state_d = NCOMP; cnt_d = 3'd0; end
      end
      NCOMP: begin
        out_valid = 1'b1;
        out_byte  = {6'd0, ns_q};
        if (fire) begin state_d = COMP; cnt_d = 3'd0; end
      end
      COMP: begin
        // Even count: component selector Cs = k+1; odd count: {DC id, AC id}.
        out_valid = 1'b1;
        out_byte  = cnt[0] ? {dc_sel, ac_sel} : {6'd0, idx} + 8'd1;
        if (fire && comp_end) begin state_d = SPEC; cnt_d = 3'd0; end
      end
      SPEC: begin
        out_valid = 1'b1;
        case (cnt)
          3'd0:    out_byte = spec_q[23:16];
          3'd1:    out_byte = spec_q[15:8];
          default: out_byte = spec_q[7:0];
        endcase
        if (fire && cnt == 3'd2) begin state_d = DONE; cnt_d = 3'd0; end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

`ifdef JPEG_SOS_GEN_LAST_EN
  assign out_last = (state == SPEC) && (cnt == 3'd2);
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_sos_gen.sv
// Bench for jpeg_sos_gen: directed vectors, stalled and random streams, illegal Ns and mid-segment reset.
module tb_jpeg_sos_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ncomp = 8'd0;
  logic [3:0]  dc_ht_0 = 4'd0, dc_ht_1 = 4'd0, dc_ht_2 = 4'd0;
  logic [3:0]  ac_ht_0 = 4'd0, ac_ht_1 = 4'd0, ac_ht_2 = 4'd0;
  logic [23:0] spec = 24'd0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid, out_last, busy, done, err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  int          m_ns;
  logic [3:0]  m_dc[3];
  logic [3:0]  m_ac[3];
  logic [23:0] m_spec;

  always #5 clk = ~clk;

  jpeg_sos_gen dut (
    .clk(clk), .rst(rst), .start(start), .ncomp(ncomp),
    .dc_ht_0(dc_ht_0), .dc_ht_1(dc_ht_1), .dc_ht_2(dc_ht_2),
    .ac_ht_0(ac_ht_0), .ac_ht_1(ac_ht_1), .ac_ht_2(ac_ht_2),
    .spec(spec), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // Reference model: the SOS segment as a byte list derived from the segment layout.
  task automatic model_build();
    int ls;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hDA);
    ls = 6 + 2 * m_ns;
    exp_q.push_back(8'(ls / 256));
    exp_q.push_back(8'(ls % 256));
    exp_q.push_back(8'(m_ns));
    for (int k = 0; k < m_ns; k++) begin
      exp_q.push_back(8'(k + 1));
      exp_q.push_back({m_dc[k], m_ac[k]});
    end
    exp_q.push_back(m_spec[23:16]);
    exp_q.push_back(m_spec[15:8]);
    exp_q.push_back(m_spec[7:0]);
  endtask

  task automatic model_random();
    m_ns = $urandom_range(1, 3);
    for (int k = 0; k < 3; k++) begin
      m_dc[k] = 4'($urandom);
      m_ac[k] = 4'($urandom);
    end
    m_spec = 24'($urandom);
  endtask

  task automatic scramble();
    ncomp   = 8'($urandom);
    dc_ht_0 = 4'($urandom); dc_ht_1 = 4'($urandom); dc_ht_2 = 4'($urandom);
    ac_ht_0 = 4'($urandom); ac_ht_1 = 4'($urandom); ac_ht_2 = 4'($urandom);
    spec    = 24'($urandom);
  endtask

  // Returns at the falling edge one cycle after the start edge; inputs are scrambled afterwards.
  task automatic drive_start(input logic [7:0] ns_in);
    @(negedge clk);
    ncomp   = ns_in;
    dc_ht_0 = m_dc[0]; dc_ht_1 = m_dc[1]; dc_ht_2 = m_dc[2];
    ac_ht_0 = m_ac[0]; ac_ht_1 = m_ac[1]; ac_ht_2 = m_ac[2];
    spec    = m_spec;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready.
  task automatic run_stream(input int mode, input string tag);
    int   total, cyc;
    logic rdy, exp_last;
    total = exp_q.size();
    cyc   = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
`ifdef JPEG_SOS_GEN_LAST_EN
      exp_last = (exp_q.size() == 1);
`else
      exp_last = 1'b0;
`endif
      checks++;
      if (out_valid !== 1'b1 || out_byte !== exp_q[0]) begin
        errors++;
        $display("FAIL %s byte %0d cyc %0d: valid=%b byte=%h, required valid=1 byte=%h",
                 tag, total - exp_q.size(), cyc, out_valid, out_byte, exp_q[0]);
      end
      checks++;
      if (out_last !== exp_last || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s flags cyc %0d: last=%b busy=%b done=%b, required last=%b busy=1 done=0",
                 tag, cyc, out_last, busy, done, exp_last);
      end
      if (rdy) void'(exp_q.pop_front());
      @(negedge clk);
      scramble();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d bytes left, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    if (mode == 0) begin
      checks++;
      if (cyc != total) begin
        errors++;
        $display("FAIL %s cycles: got %0d, required %0d", tag, cyc, total);
      end
    end
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b busy=%b valid=%b, required 1 1 0", tag, done, busy, out_valid);
    end
    // A start in the DONE cycle must be ignored.
    ncomp = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b, required 0 0 0", tag, done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    scramble();
    start = 1'b1;
    #13;
    checks++;
    if (out_byte !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: byte=%h valid=%b last=%b busy=%b done=%b err=%b, required all 0",
               out_byte, out_valid, out_last, busy, done, err);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_vectors();
    m_ns = 3; m_dc = '{4'd0, 4'd1, 4'd1}; m_ac = '{4'd0, 4'd1, 4'd1}; m_spec = 24'h003F00;
    model_build();
    drive_start(8'(m_ns));
    run_stream(0, "vec_ns3");
    m_ns = 1; m_dc = '{4'd2, 4'd7, 4'd9}; m_ac = '{4'd3, 4'd5, 4'd6}; m_spec = 24'h013F21;
    model_build();
    drive_start(8'(m_ns));
    run_stream(0, "vec_ns1");
  endtask

  task automatic test_stall();
    m_ns = 3; m_dc = '{4'd0, 4'd1, 4'd1}; m_ac = '{4'd0, 4'd1, 4'd1}; m_spec = 24'h003F00;
    model_build();
    drive_start(8'(m_ns));
    run_stream(1, "stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      model_random();
      model_build();
      drive_start(8'(m_ns));
      run_stream((i % 2 == 0) ? 2 : 0, "random");
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bad[3];
    bad[0] = 8'd0;
    bad[1] = 8'd5;
    bad[2] = 8'($urandom_range(4, 255));
    for (int i = 0; i < 3; i++) begin
      model_random();
      drive_start(bad[i]);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL illegal_%0d done_cycle: valid=%b done=%b err=%b busy=%b, required 0 1 1 1",
                 bad[i], out_valid, done, err, busy);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d idle: valid=%b done=%b err=%b busy=%b, required 0 0 1 0",
                 bad[i], out_valid, done, err, busy);
      end
    end
    model_random();
    model_build();
    drive_start(8'(m_ns));
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
    run_stream(0, "after_illegal");
  endtask

  task automatic test_reset_mid();
    model_random();
    drive_start(8'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b, required 0", err);
    end
    @(negedge clk);
    rst = 1'b1;
    m_ns = 3;
    model_build();
    drive_start(8'(m_ns));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== exp_q[0]) begin
        errors++;
        $display("FAIL midrst_pre byte %0d: valid=%b byte=%h, required valid=1 byte=%h",
                 i, out_valid, out_byte, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_byte !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: byte=%h valid=%b last=%b busy=%b done=%b err=%b state=%0d, required all 0",
               out_byte, out_valid, out_last, busy, done, err, state_dbg);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_resume: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    model_build();
    drive_start(8'(m_ns));
    run_stream(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
